// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache definitions: fill-state enum, block geometry and the address
// tag/index/offset split helpers used by the cache arrays.
package cache_pkg;

  localparam int ADDR_WIDTH  = 16;
  localparam int BLOCK_WORDS = 8;
  localparam int BLOCK_BYTES = 2 * BLOCK_WORDS;
  localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);
  localparam int WORD_BITS   = $clog2(BLOCK_WORDS);
  localparam int INDEX_BITS  = 6;
  localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fill_state_e;

  function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [ADDR_WIDTH-1:0] addr);
    return OFFSET_BITS'(addr);
  endfunction

  function automatic logic [INDEX_BITS-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
    return INDEX_BITS'(addr >> OFFSET_BITS);
  endfunction

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
    return TAG_BITS'(addr >> (ADDR_WIDTH - TAG_BITS));
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bundle between the fill controller, the cache lookup/array side and the
// memory read port.
interface cache_fill_fsm_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
);
  localparam int WORD_BITS = $clog2(BLOCK_WORDS);

  // Memory port has no back-pressure: every cycle with mem_en high is one
  // accepted read, and each memory_data_valid cycle carries exactly one word,
  // returned in request order.
  logic                   miss_detected;
  logic [ADDR_WIDTH-1:0]  miss_address;
  logic [15:0]            memory_data;
  logic                   memory_data_valid;
  logic                   fsm_busy;
  logic                   mem_en;
  logic [ADDR_WIDTH-1:0]  memory_address;
  logic                   write_data_array;
  logic [WORD_BITS-1:0]   word_sel;
  logic                   write_tag_array;

  modport master (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, mem_en, memory_address, write_data_array, word_sel,
           write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, mem_en, memory_address, write_data_array, word_sel,
           write_tag_array
  );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// Up-counter with synchronous clear and an all-ones terminal-count flag;
// wraps naturally because block sizes are powers of two.
module fill_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = &count;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: issues one pipelined word read per cycle for the
// missed block, steers returned words into the data array, then writes the tag.
// Optional fill statistics counter enabled by defining CACHE_FILL_STATS_EN.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
  parameter int ADDR_WIDTH  = cache_pkg::ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cache_fill_fsm_if.master       bus,
  output fill_state_e            state_dbg
`ifdef CACHE_FILL_STATS_EN
  ,
  output logic [15:0]            fill_count
`endif
);

  localparam int WORD_BITS = $clog2(BLOCK_WORDS);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(2 * BLOCK_WORDS - 1);

  fill_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  busy_q;
  logic [WORD_BITS-1:0]  issue_cnt, rx_cnt;
  logic                  issue_last, rx_last;
  logic                  rx_inc, fill_done, cnt_clr;

  // Responses count independently of issue so they may overlap REQ.
  assign rx_inc    = bus.memory_data_valid && (state_q != IDLE);
  assign fill_done = rx_inc && rx_last;
  assign cnt_clr   = (state_q != IDLE) && (state_d == IDLE);

  fill_counter #(.WIDTH(WORD_BITS)) u_issue (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (state_q == REQ),
    .count (issue_cnt),
    .tc    (issue_last)
  );

  fill_counter #(.WIDTH(WORD_BITS)) u_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (rx_inc),
    .count (rx_cnt),
    .tc    (rx_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      if (state_q == IDLE && bus.miss_detected) begin
        base_q <= bus.miss_address & ~OFF_MASK;
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    bus.mem_en           = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = rx_inc;
    bus.word_sel         = rx_cnt;
    bus.write_tag_array  = fill_done;
    bus.fsm_busy         = busy_q;
    unique case (state_q)
      IDLE: if (bus.miss_detected) state_d = REQ;
      REQ: begin
        bus.mem_en = 1'b1;
        // Low offset bits of base are zero, so OR never carries out of the block.
        bus.memory_address = base_q | ADDR_WIDTH'({issue_cnt, 1'b0});
        if (issue_last) state_d = fill_done ? IDLE : WAIT;
      end
      WAIT: if (fill_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign state_dbg = state_q;

`ifdef CACHE_FILL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_count <= '0;
    end else if (fill_done && fill_count != 16'hFFFF) begin
      fill_count <= fill_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a latency-configurable memory model, a cycle-level
// reference derived from the fill timing rules, and a data scoreboard.
module tb_cache_fill_fsm;
  import cache_pkg::*;

  localparam int BW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_fill_fsm_if ifc ();
  fill_state_e state_dbg;
`ifdef CACHE_FILL_STATS_EN
  logic [15:0] fill_count;
`endif

  cache_fill_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc),
    .state_dbg (state_dbg)
`ifdef CACHE_FILL_STATS_EN
    ,
    .fill_count(fill_count)
`endif
  );

  // ---------------- bench state ----------------
  typedef struct {
    int          due;
    logic [15:0] addr;
  } mreq_t;

  typedef struct {
    logic [15:0] addr;
    int          lat;
    logic [15:0] first;
    logic [15:0] last;
    int          tag_rel;
    logic [15:0] tag_addr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mreq_t       mem_q[$];
  logic [15:0] exp_q[$];

  logic        drv_miss = 1'b0;
  logic [15:0] drv_addr = '0;
  logic        drv_spurious = 1'b0;
  int          lat = 0;

  int          m_start = -1000;
  int          m_lat = 0;
  logic [15:0] m_base = '0;
  int          exp_fc = 0;

  logic        have_first;
  logic [15:0] first_req, last_req, tag_addr;
  int          req_cnt, wr_cnt, tag_cnt, tag_cyc, miss_cyc;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_rec();
    have_first = 1'b0;
    first_req = '0;
    last_req = '0;
    tag_addr = '0;
    req_cnt = 0;
    wr_cnt = 0;
    tag_cnt = 0;
    tag_cyc = -1;
  endtask

  // ---------------- one clock cycle: drive, model, compare ----------------
  task automatic step();
    int          d, sel_e;
    logic        busy_e, en_e, wr_e, tag_e, mv;
    logic [15:0] addr_e, md;
    fill_state_e st_e;
    mreq_t       r;
    @(posedge clk);
    #1;
    cyc++;
    d = cyc - m_start;
    busy_e = rst_n && (d >= 0) && (d <= BW - 1 + m_lat);
    if (rst_n && ifc.mem_en) begin
      r.due = cyc + m_lat;
      r.addr = ifc.memory_address;
      mem_q.push_back(r);
    end
    mv = 1'b0;
    md = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      mv = 1'b1;
      md = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else if (drv_spurious && !busy_e) begin
      mv = 1'b1;
      md = 16'hDEAD;
    end
    ifc.memory_data_valid = mv;
    ifc.memory_data = md;
    ifc.miss_detected = drv_miss;
    ifc.miss_address = drv_addr;
    #1;
    en_e = busy_e && (d < BW);
    addr_e = en_e ? m_base + 16'(2 * d) : 16'h0;
    wr_e = mv && busy_e;
    tag_e = wr_e && (d == BW - 1 + m_lat);
    sel_e = !busy_e ? 0 : (d < m_lat ? 0 : ((d - m_lat > BW - 1) ? BW - 1 : d - m_lat));
    st_e = !busy_e ? IDLE : (d < BW ? REQ : WAIT);
    chk("fsm_busy", 32'(ifc.fsm_busy), 32'(busy_e));
    chk("mem_en", 32'(ifc.mem_en), 32'(en_e));
    chk("memory_address", 32'(ifc.memory_address), 32'(addr_e));
    chk("write_data_array", 32'(ifc.write_data_array), 32'(wr_e));
    chk("word_sel", 32'(ifc.word_sel), 32'(sel_e));
    chk("write_tag_array", 32'(ifc.write_tag_array), 32'(tag_e));
    chk("state", 32'(state_dbg), 32'(st_e));
`ifdef CACHE_FILL_STATS_EN
    chk("fill_count", 32'(fill_count), 32'(exp_fc));
    if (tag_e && exp_fc != 65535) exp_fc++;
`endif
    // scoreboard of words landing in the data array
    if (ifc.write_data_array) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL array_write_unexpected: got word_sel %0d expected no write at cycle %0d",
                 ifc.word_sel, cyc);
      end else begin
        chk("array_data", 32'(ifc.memory_data), 32'(exp_q.pop_front()));
      end
    end
    if (ifc.mem_en) begin
      if (!have_first) first_req = ifc.memory_address;
      have_first = 1'b1;
      last_req = ifc.memory_address;
      req_cnt++;
    end
    if (ifc.write_tag_array) begin
      tag_cnt++;
      tag_cyc = cyc;
      tag_addr = ifc.memory_address;
    end
    if (rst_n && !busy_e && drv_miss) begin
      m_start = cyc + 1;
      m_base = drv_addr & 16'hFFF0;
      m_lat = lat;
      miss_cyc = cyc;
      for (int k = 0; k < BW; k++) exp_q.push_back(mem_word(m_base + 16'(2 * k)));
    end
  endtask

  task automatic run_fill(input logic [15:0] addr, input int l, input logic hold);
    drv_addr = addr;
    drv_miss = 1'b1;
    lat = l;
    clear_rec();
    step();
    if (!hold) drv_miss = 1'b0;
    for (int i = 0; i < BW + l; i++) step();
    drv_miss = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(ifc.fsm_busy), 32'd0);
    chk({tag, "_mem_en"}, 32'(ifc.mem_en), 32'd0);
    chk({tag, "_addr"}, 32'(ifc.memory_address), 32'd0);
    chk({tag, "_wr"}, 32'(ifc.write_data_array), 32'd0);
    chk({tag, "_sel"}, 32'(ifc.word_sel), 32'd0);
    chk({tag, "_tag"}, 32'(ifc.write_tag_array), 32'd0);
    chk({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
`ifdef CACHE_FILL_STATS_EN
    chk({tag, "_fill_count"}, 32'(fill_count), 32'd0);
`endif
  endtask

  // Asynchronous reset asserted mid-cycle, held for one edge, released mid-cycle.
  task automatic pulse_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    mem_q.delete();
    exp_q.delete();
    m_start = -1000;
    exp_fc = 0;
    drv_miss = 1'b0;
    drv_spurious = 1'b0;
    step();
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    vec_t vecs[6];
    vecs[0] = '{addr: 16'h1236, lat: 4, first: 16'h1230, last: 16'h123E, tag_rel: 12, tag_addr: 16'h0000};
    vecs[1] = '{addr: 16'hFFFE, lat: 0, first: 16'hFFF0, last: 16'hFFFE, tag_rel: 8,  tag_addr: 16'hFFFE};
    vecs[2] = '{addr: 16'h0000, lat: 1, first: 16'h0000, last: 16'h000E, tag_rel: 9,  tag_addr: 16'h0000};
    vecs[3] = '{addr: 16'hABCE, lat: 2, first: 16'hABC0, last: 16'hABCE, tag_rel: 10, tag_addr: 16'h0000};
    vecs[4] = '{addr: 16'h7FF0, lat: 3, first: 16'h7FF0, last: 16'h7FFE, tag_rel: 11, tag_addr: 16'h0000};
    vecs[5] = '{addr: 16'h5558, lat: 5, first: 16'h5550, last: 16'h555E, tag_rel: 13, tag_addr: 16'h0000};

    ifc.miss_detected = 1'b0;
    ifc.miss_address = '0;
    ifc.memory_data = '0;
    ifc.memory_data_valid = 1'b0;
    clear_rec();
    miss_cyc = 0;
    #1;
    check_reset_outputs("reset_init");
    step();
    step();
    #3;
    rst_n = 1'b1;

    // table-driven single fills
    for (int v = 0; v < 6; v++) begin
      run_fill(vecs[v].addr, vecs[v].lat, 1'b0);
      step();
      chk("vec_first_req", 32'(first_req), 32'(vecs[v].first));
      chk("vec_last_req", 32'(last_req), 32'(vecs[v].last));
      chk("vec_req_cnt", 32'(req_cnt), 32'(BW));
      chk("vec_wr_cnt", 32'(wr_cnt), 32'(BW));
      chk("vec_tag_cnt", 32'(tag_cnt), 32'd1);
      chk("vec_tag_cycle", 32'(tag_cyc - miss_cyc), 32'(vecs[v].tag_rel));
      chk("vec_tag_req_addr", 32'(tag_addr), 32'(vecs[v].tag_addr));
      chk("vec_busy_after", 32'(ifc.fsm_busy), 32'd0);
      chk("vec_exp_q_drained", 32'(exp_q.size()), 32'd0);
    end

    // spurious responses while idle
    clear_rec();
    drv_spurious = 1'b1;
    for (int i = 0; i < 6; i++) step();
    drv_spurious = 1'b0;
    chk("spurious_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("spurious_word_sel", 32'(ifc.word_sel), 32'd0);

    // miss held high throughout a fill, address changing underneath
    lat = 2;
    drv_addr = 16'h2468;
    drv_miss = 1'b1;
    clear_rec();
    step();
    drv_addr = 16'h9ABC;
    for (int i = 0; i < BW + 2; i++) step();
    chk("hold_first_req", 32'(first_req), 32'h2460);
    chk("hold_req_cnt", 32'(req_cnt), 32'(BW));
    chk("hold_tag_cnt", 32'(tag_cnt), 32'd1);
    clear_rec();
    step();
    drv_miss = 1'b0;
    for (int i = 0; i < BW + 2; i++) step();
    step();
    chk("hold_next_first_req", 32'(first_req), 32'h9AB0);
    chk("hold_next_req_cnt", 32'(req_cnt), 32'(BW));
    chk("hold_next_tag_cnt", 32'(tag_cnt), 32'd1);

    // reset in cycle 5 of a fill, then three back-to-back clean fills
    lat = 4;
    drv_addr = 16'h4442;
    drv_miss = 1'b1;
    clear_rec();
    step();
    drv_miss = 1'b0;
    for (int i = 0; i < 5; i++) step();
    pulse_reset();
    chk("reset_no_tag", 32'(tag_cnt), 32'd0);
    step();
    run_fill(16'h4442, 4, 1'b0);
    chk("after_reset_first_req", 32'(first_req), 32'h4440);
    chk("after_reset_tag_cnt", 32'(tag_cnt), 32'd1);
    run_fill(16'h0102, 0, 1'b0);
    run_fill(16'hEEE4, 3, 1'b0);
    step();
`ifdef CACHE_FILL_STATS_EN
    chk("fill_count_three", 32'(fill_count), 32'd3);
`endif

    // randomized fills with gaps, idle noise and held misses
    for (int n = 0; n < 30; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        drv_spurious = 1'($urandom_range(0, 1));
        step();
      end
      drv_spurious = 1'b0;
      run_fill(16'($urandom_range(0, 65535)) & 16'hFFFE, $urandom_range(0, 5),
               1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) step();
    chk("final_exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("final_mem_q_drained", 32'(mem_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between the cache arrays and main memory. On a cache miss it fetches the whole block containing the missed address: one 16-bit word read per cycle, pipelined, from the memory port. It steers each returned word into the cache data array and writes the tag once the last word lands. One instance serves each cache, I and D. Main memory is the byte-addressed, 16-bit-wide unit, and bit 0 of every address is 0.

## Interface
- BLOCK_WORDS, 8 — words per cache block; power of two, ≥2; block size in bytes = 2·BLOCK_WORDS
- ADDR_WIDTH, 16 — byte-address width
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset: asynchronous, active-low
- miss_detected  in  1  cache lookup missed this cycle; sampled only in IDLE
- miss_address  in  ADDR_WIDTH  byte address of the miss; sampled with miss_detected
- memory_data  in  16  read data returning from memory
- memory_data_valid  in  1  memory_data holds a valid response this cycle
- fsm_busy  out  1  fill in progress; the pipeline stalls on it
- mem_en  out  1  read request to memory this cycle (write strobe is always 0)
- memory_address  out  ADDR_WIDTH  byte address of the current request
- write_data_array  out  1  write memory_data into the data array this cycle
- word_sel  out  log2(BLOCK_WORDS)  word index within the block for write_data_array
- write_tag_array  out  1  write the tag and set the valid bit for the block (one-cycle pulse)
- fill_count  out  16  completed-fill counter; present only with CACHE_FILL_STATS_EN

## Operation
- States:
  - IDLE: on miss_detected → REQ; latch base = miss_address with the low log2(2·BLOCK_WORDS) bits cleared.
  - REQ: issue one request per cycle; leave after the request with issue index BLOCK_WORDS-1.
    - If the last response has not yet arrived → WAIT.
    - If the last response arrives in the same cycle → IDLE.
  - WAIT: stay until the last response arrives → IDLE.
- Request k (k = 0..BLOCK_WORDS-1) is at memory_address = base + 2k, with mem_en=1.
  - mem_en=0 in IDLE and WAIT.
  - memory_address = 0 when mem_en=0.
- The response counter rx starts at 0 and increments on each memory_data_valid while state≠IDLE.
- Responses are in request order. The counter is independent of the issue index, so responses may overlap REQ.
- write_data_array = memory_data_valid & (state≠IDLE); word_sel = rx (combinational).
- write_tag_array = memory_data_valid & (rx == BLOCK_WORDS-1) & (state≠IDLE).
- fsm_busy = (state≠IDLE), registered.
- memory_data_valid in IDLE is ignored: no array write, no counter change.
- miss_detected outside IDLE is ignored. The cache re-asserts it after the stall; the refilled line then hits.
- A miss presented in the first IDLE cycle after a fill starts a new fill normally.
- Issue and rx counters wrap to 0 on entering IDLE. Address arithmetic never carries out of the block.

## Timing
- Reset value of every output: fsm_busy=0, mem_en=0, memory_address=0, write_data_array=0, write_tag_array=0, word_sel=0, fill_count=0.
- Reset state is IDLE with counters at 0.
- Reset mid-fill aborts immediately (asynchronously). No tag write occurs, and the partially written block stays invalid.
- Miss sampled at edge 0:
  - REQ spans cycles 1..BLOCK_WORDS.
  - With memory response latency L cycles after request, the tag write falls in cycle BLOCK_WORDS+L.
  - fsm_busy deasserts at the edge ending that cycle.
- Zero-latency memory (L=0, response in the request cycle) is legal: REQ → IDLE directly, no WAIT.

## Configuration
- CACHE_FILL_STATS_EN defined: fill_count port and register exist.
  - Increments by 1 on every write_tag_array.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: no fill_count port, no register; all other behaviour is identical.

## Structure
- Shared package cache_pkg:
  - fill-state enum (IDLE, REQ, WAIT)
  - BLOCK_WORDS / BLOCK_BYTES / OFFSET_BITS constants
  - the tag/index/offset split functions used by the cache arrays
- One natural sub-module, fill_counter: a parameterised up-counter with clear and terminal-count flag. It is instantiated twice, for issue and rx.

## Test plan
- Miss at 0x1236, L=4 memory:
  - Requests 0x1230..0x123E on consecutive cycles.
  - Eight write_data_array pulses with word_sel 0..7.
  - write_tag_array exactly once, in cycle 12.
  - fsm_busy low at cycle 13.
- L=0 memory, miss at 0xFFFE:
  - Requests 0xFFF0..0xFFFE.
  - The tag pulse coincides with the request to 0xFFFE.
  - No WAIT cycle; no address wrap past 0xFFFE.
- miss_detected held high throughout a fill:
  - No restart.
  - The next fill starts only after fsm_busy falls, with requests from the new base.
- Spurious memory_data_valid while IDLE → no array writes; word_sel stays 0.
- rst_n pulled low in cycle 5 of a fill (L=4):
  - All outputs 0 immediately; no tag write.
  - The next miss fills cleanly from word 0.
- With CACHE_FILL_STATS_EN: three back-to-back fills → fill_count = 3. Without the macro the bench compiles without the port.
